// File: rtl/banco_registros.sv
// banco_registros: register file, 2**ADDR_WIDTH x DATA_WIDTH. It has two combinational
// read ports and one synchronous write port. Register 0 always reads as zero.
//
// Ports:
//   CLK        clock; all state changes happen on the rising edge
//   reset      synchronous active-high clear of every register
//   A1, A2     read port addresses
//   A3         write port address
//   WD3        write data
//   WE3        write enable, active-high
//   RD1, RD2   read data for A1 / A2 (combinational, zero latency)
//
// Optional feature: define BANCO_REGISTROS_BYPASS_EN to forward WD3 to a read port.
// Forwarding happens when that port addresses the register being written in the same cycle.
module banco_registros #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic                  WE3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef word_t regs_t [NUM_REGS];

    // Declaration initialiser makes reads defined before the first reset edge.
    regs_t regs_q = '{default: '0};
    regs_t regs_d;

    // A write to address 0 is dropped, so regs_q[0] keeps its initial zero.
    logic wr_en;
    assign wr_en = WE3 && (A3 != '0);

    // Next-state: the current contents, plus the write.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[A3] = WD3;
        end
    end

    // Storage. Reset takes priority over the write.
    always_ff @(posedge CLK) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port 1.
    always_comb begin
        RD1 = regs_q[A1];
`ifdef BANCO_REGISTROS_BYPASS_EN
        if (wr_en && !reset && (A1 == A3)) begin
            RD1 = WD3;
        end
`endif
        if (A1 == '0) begin
            RD1 = '0;
        end
    end

    // Read port 2.
    always_comb begin
        RD2 = regs_q[A2];
`ifdef BANCO_REGISTROS_BYPASS_EN
        if (wr_en && !reset && (A2 == A3)) begin
            RD2 = WD3;
        end
`endif
        if (A2 == '0) begin
            RD2 = '0;
        end
    end

endmodule

// File: tb/tb_banco_registros.sv
// Self-checking bench for banco_registros. It runs directed scenarios, then random traffic.
// Results are checked against an array model of the register file.
module tb_banco_registros;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2 ** AW;

    logic          CLK = 1'b0;
    logic          reset;
    logic [AW-1:0] A1, A2, A3;
    logic [DW-1:0] WD3;
    logic          WE3;
    logic [DW-1:0] RD1, RD2;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [NR];

`ifdef BANCO_REGISTROS_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    banco_registros #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK  (CLK),
        .reset(reset),
        .A1   (A1),
        .A2   (A2),
        .A3   (A3),
        .WD3  (WD3),
        .WE3  (WE3),
        .RD1  (RD1),
        .RD2  (RD2)
    );

    always #5 CLK = ~CLK;

    // Expected read value for the inputs currently applied.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (BYPASS && WE3 && !reset && (A3 != '0) && (a == A3)) return WD3;
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, ".rd1"}, RD1, exp_rd(A1));
        check({tag, ".rd2"}, RD2, exp_rd(A2));
    endtask

    // Apply the inputs and check them before the edge. Then clock, update the model and check again.
    task automatic cycle(input string tag, input logic rst, input logic we,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] a3, input logic [DW-1:0] wd);
        reset = rst; WE3 = we; A1 = a1; A2 = a2; A3 = a3; WD3 = wd;
        #1;
        check_ports({tag, ".pre"});
        @(posedge CLK);
        if (rst) begin
            for (int i = 0; i < int'(NR); i++) model[i] = '0;
        end else if (we && (a3 != '0)) begin
            model[a3] = wd;
        end
        #1;
        check_ports({tag, ".post"});
    endtask

    initial begin
        for (int i = 0; i < int'(NR); i++) model[i] = '0;
        reset = 1'b0; WE3 = 1'b0; A1 = AW'(3); A2 = AW'(31); A3 = '0; WD3 = '0;

        // Reads are zero before any reset.
        #1;
        check("init.rd1", RD1, '0);
        check("init.rd2", RD2, '0);

        cycle("rst0", 1'b1, 1'b0, AW'(1), AW'(2), '0, '0);

        // Two writes, then read both registers back.
        cycle("w10", 1'b0, 1'b1, AW'(10), AW'(5), AW'(10), DW'(32'hFF));
        cycle("w5",  1'b0, 1'b1, AW'(10), AW'(5), AW'(5),  DW'(32'h12F));
        cycle("rd",  1'b0, 1'b0, AW'(10), AW'(5), AW'(5),  DW'(32'h0));
        check("rd10.const", RD1, DW'(32'hFF));
        check("rd5.const",  RD2, DW'(32'h12F));

        // Reset clears everything; contents hold until the edge.
        reset = 1'b1;
        #1;
        check("rst.pre.rd1", RD1, DW'(32'hFF));
        cycle("rst1", 1'b1, 1'b0, AW'(10), AW'(5), '0, '0);
        check("rst.post.rd1", RD1, '0);
        check("rst.post.rd2", RD2, '0);

        // A write to register 0 is discarded.
        cycle("w0", 1'b0, 1'b1, AW'(0), AW'(0), AW'(0), DW'(32'hDEADBEEF));
        check("w0.const", RD1, '0);

        // With WE3 low, nothing is written.
        cycle("we0", 1'b0, 1'b0, AW'(7), AW'(7), AW'(7), DW'(32'h1234));
        check("we0.const", RD1, '0);

        // Reset wins over a simultaneous write.
        cycle("pre3", 1'b0, 1'b1, AW'(3), AW'(3), AW'(3), DW'(32'h55));
        cycle("rstwe", 1'b1, 1'b1, AW'(3), AW'(3), AW'(3), DW'(32'hAA));
        check("rstwe.const", RD2, '0);

        // Read of the register being written in the same cycle.
        cycle("w4", 1'b0, 1'b1, AW'(0), AW'(0), AW'(4), DW'(32'h11));
        reset = 1'b0; WE3 = 1'b1; A3 = AW'(4); WD3 = DW'(32'h22); A1 = AW'(4); A2 = AW'(4);
        #1;
        check("byp.pre.const", RD1, BYPASS ? DW'(32'h22) : DW'(32'h11));
        cycle("byp", 1'b0, 1'b1, AW'(4), AW'(4), AW'(4), DW'(32'h22));
        check("byp.post.const", RD1, DW'(32'h22));

        // Random traffic. Some cycles force a read port onto the write address.
        for (int n = 0; n < 400; n++) begin
            logic          r_rst, r_we;
            logic [AW-1:0] r_a1, r_a2, r_a3;
            logic [DW-1:0] r_wd;
            r_rst = ($urandom_range(0, 29) == 0);
            r_we  = $urandom_range(0, 1) == 1;
            r_a3  = AW'($urandom_range(0, NR - 1));
            r_a1  = AW'($urandom_range(0, NR - 1));
            r_a2  = AW'($urandom_range(0, NR - 1));
            r_wd  = DW'($urandom);
            if ($urandom_range(0, 3) == 0) r_a1 = r_a3;
            if ($urandom_range(0, 3) == 0) r_a2 = r_a3;
            if ($urandom_range(0, 7) == 0) r_a2 = r_a1;
            cycle("rnd", r_rst, r_we, r_a1, r_a2, r_a3, r_wd);
        end

        // Read every register back on both ports.
        for (int i = 0; i < int'(NR); i++) begin
            reset = 1'b0; WE3 = 1'b0; A1 = AW'(i); A2 = AW'(NR - 1 - i);
            #1;
            check_ports("sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
